// File: rtl/display_scan_controller_if.sv
// rtl/display_scan_controller_if.sv - host-side and controller-side signals of the digit scan controller
interface display_scan_controller_if;
  logic        EN;
  logic [15:0] VALUE;
  logic [3:0]  DP_IN;
  logic        LOAD;
  logic        BLANK_LZ;
  logic        S0;
  logic        S1;
  logic [3:0]  DIGIT;
  logic        DP;
  logic        BLANK;
  logic        FRAME;

  modport master (
    output EN, VALUE, DP_IN, LOAD, BLANK_LZ,
    input  S0, S1, DIGIT, DP, BLANK, FRAME
  );

  modport slave (
    input  EN, VALUE, DP_IN, LOAD, BLANK_LZ,
    output S0, S1, DIGIT, DP, BLANK, FRAME
  );
endinterface

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - four-digit multiplexed display scanner with frame-aligned data update
module display_scan_controller #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  display_scan_controller_if.slave bus
);

  localparam int              PW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  logic [15:0]   r_pend;
  logic [3:0]    r_pend_dp;
  logic          r_pend_vld;
  logic          r_frame;

  logic          w_tick;
  logic          w_wrap;
  logic          w_xfer;
  logic [2:0]    w_lz;
  logic          w_lz_cur;
  logic [3:0]    w_digit;
  logic          w_dp;

  assign w_tick = bus.EN && (r_presc == LAST);
  assign w_wrap = w_tick && (r_idx == 2'd3);
  // Holding the display (EN=0) is a safe moment to swap data, as is the frame wrap.
  assign w_xfer = w_wrap || !bus.EN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= 2'd0;
      r_shadow    <= 16'h0000;
      r_shadow_dp <= 4'h0;
      r_pend      <= 16'h0000;
      r_pend_dp   <= 4'h0;
      r_pend_vld  <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      if (!bus.EN || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end

      r_frame <= w_wrap;

      if (w_xfer && r_pend_vld) begin
        r_shadow    <= r_pend;
        r_shadow_dp <= r_pend_dp;
        r_pend_vld  <= 1'b0;
      end

      // A coincident LOAD lands after the transfer, so it stays pending.
      if (bus.LOAD) begin
        r_pend     <= bus.VALUE;
        r_pend_dp  <= bus.DP_IN;
        r_pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_digit = 4'h0;
    w_dp    = 1'b0;
    case (r_idx)
      2'd0: begin w_digit = r_shadow[15:12]; w_dp = r_shadow_dp[3]; end
      2'd1: begin w_digit = r_shadow[11:8];  w_dp = r_shadow_dp[2]; end
      2'd2: begin w_digit = r_shadow[7:4];   w_dp = r_shadow_dp[1]; end
      default: begin w_digit = r_shadow[3:0]; w_dp = r_shadow_dp[0]; end
    endcase
  end

  assign w_lz[0] = (r_shadow[15:12] == 4'h0) && !r_shadow_dp[3];
  assign w_lz[1] = w_lz[0] && (r_shadow[11:8] == 4'h0) && !r_shadow_dp[2];
  assign w_lz[2] = w_lz[1] && (r_shadow[7:4] == 4'h0) && !r_shadow_dp[1];

  // The rightmost digit is never a leading zero, so it has no blanking term.
  assign w_lz_cur = ((r_idx == 2'd0) && w_lz[0]) ||
                    ((r_idx == 2'd1) && w_lz[1]) ||
                    ((r_idx == 2'd2) && w_lz[2]);

  assign bus.S0    = r_idx[1];
  assign bus.S1    = r_idx[0];
  assign bus.DIGIT = w_digit;
  assign bus.DP    = w_dp;
  assign bus.BLANK = !bus.EN || (bus.BLANK_LZ && w_lz_cur);
  assign bus.FRAME = r_frame;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cur_n = -1;

  always #5 clk = ~clk;

  display_scan_controller_if bus ();

  display_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cur_n, obs, exp);
    end
  endtask

  logic [15:0] fv  [0:8];
  logic [3:0]  fdp [0:8];

  initial begin
    int          f;
    int          ix;
    logic [15:0] v;
    logic [3:0]  dpv;
    logic [3:0]  e_d;
    logic        e_dp;
    logic        e_blank;
    logic        e_frame;

    fv  = '{16'h0000, 16'h1234, 16'hABCD, 16'h2222, 16'h3333, 16'h0050, 16'h0050, 16'h0050, 16'h0050};
    fdp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 4'b0100};

    rst_n        = 1'b0;
    bus.EN       = 1'b0;
    bus.VALUE    = 16'h0000;
    bus.DP_IN    = 4'h0;
    bus.LOAD     = 1'b0;
    bus.BLANK_LZ = 1'b0;

    @(posedge clk); #2;
    chk("rst_idx",   {14'd0, bus.S0, bus.S1}, 16'd0);
    chk("rst_digit", {12'd0, bus.DIGIT}, 16'd0);
    chk("rst_dp",    {15'd0, bus.DP}, 16'd0);
    chk("rst_frame", {15'd0, bus.FRAME}, 16'd0);
    chk("rst_blank_en0", {15'd0, bus.BLANK}, 16'd1);

    bus.EN = 1'b1; bus.BLANK_LZ = 1'b1; bus.LOAD = 1'b1;
    bus.VALUE = 16'hFFFF; bus.DP_IN = 4'hF;
    #1;
    chk("rst_blank_lz", {15'd0, bus.BLANK}, 16'd1);
    @(posedge clk); #2;
    chk("rst_hold_digit", {12'd0, bus.DIGIT}, 16'd0);
    chk("rst_hold_dp",    {15'd0, bus.DP}, 16'd0);
    chk("rst_hold_idx",   {14'd0, bus.S0, bus.S1}, 16'd0);

    for (int n = 0; n <= 170; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      cur_n        = n;
      rst_n        = (n != 153);
      bus.LOAD     = 1'b0;
      bus.VALUE    = 16'h0000;
      bus.DP_IN    = 4'h0;
      bus.EN       = !(n >= 137 && n <= 146);
      bus.BLANK_LZ = (n >= 80 && n < 96) || (n >= 112 && n < 128) || (n >= 154);
      case (n)
        0:   begin bus.LOAD = 1'b1; bus.VALUE = 16'h1234; end
        20:  begin bus.LOAD = 1'b1; bus.VALUE = 16'hABCD; end
        33:  begin bus.LOAD = 1'b1; bus.VALUE = 16'h1111; end
        38:  begin bus.LOAD = 1'b1; bus.VALUE = 16'h2222; end
        47:  begin bus.LOAD = 1'b1; bus.VALUE = 16'h3333; end
        65:  begin bus.LOAD = 1'b1; bus.VALUE = 16'h0050; end
        97:  begin bus.LOAD = 1'b1; bus.VALUE = 16'h0050; bus.DP_IN = 4'b0100; end
        139: begin bus.LOAD = 1'b1; bus.VALUE = 16'h9876; end
        151: begin bus.LOAD = 1'b1; bus.VALUE = 16'h5555; end
        default: ;
      endcase
      #1;

      if (n <= 136) begin
        f       = n / 16;
        ix      = (n / 4) % 4;
        v       = fv[f];
        dpv     = fdp[f];
        e_d     = 4'(v >> (4 * (3 - ix)));
        e_dp    = dpv[3 - ix];
        e_frame = (n % 16 == 0) && (n >= 16);
        e_blank = (f == 5 && ix < 2) || (f == 7 && ix == 0);
      end else if (n <= 146) begin
        ix = 2; e_d = (n <= 140) ? 4'h5 : 4'h7; e_dp = 1'b0; e_blank = 1'b1; e_frame = 1'b0;
      end else if (n <= 150) begin
        ix = 2; e_d = 4'h7; e_dp = 1'b0; e_blank = 1'b0; e_frame = 1'b0;
      end else if (n <= 153) begin
        ix = 3; e_d = 4'h6; e_dp = 1'b0; e_blank = 1'b0; e_frame = 1'b0;
      end else if (n <= 169) begin
        ix = (n - 154) / 4; e_d = 4'h0; e_dp = 1'b0; e_blank = (ix < 3); e_frame = 1'b0;
      end else begin
        ix = 0; e_d = 4'h0; e_dp = 1'b0; e_blank = 1'b1; e_frame = 1'b1;
      end

      chk("idx",   {14'd0, bus.S0, bus.S1}, 16'(ix));
      chk("digit", {12'd0, bus.DIGIT}, {12'd0, e_d});
      chk("dp",    {15'd0, bus.DP}, {15'd0, e_dp});
      chk("blank", {15'd0, bus.BLANK}, {15'd0, e_blank});
      chk("frame", {15'd0, bus.FRAME}, {15'd0, e_frame});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL be the clk cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 EN  input  1  SHALL be the scan enable; 1 = scanning, 0 = hold and blank.
REQ-005 VALUE  input  16  SHALL be the display data, four nibbles; VALUE[15:12] = digit 0 (leftmost), VALUE[3:0] = digit 3.
REQ-006 DP_IN  input  4  SHALL be the decimal-point request; DP_IN[3] = digit 0, DP_IN[0] = digit 3.
REQ-007 LOAD  input  1  SHALL be a one-cycle strobe requesting capture of VALUE and DP_IN.
REQ-008 BLANK_LZ  input  1  SHALL enable leading-zero blanking when 1.
REQ-009 S0  output  1  SHALL be the digit index MSB, driving the anode selector select S0.
REQ-010 S1  output  1  SHALL be the digit index LSB, driving the anode selector select S1.
REQ-011 DIGIT  output  4  SHALL be the nibble for the currently selected digit.
REQ-012 DP  output  1  SHALL be the decimal-point bit for the currently selected digit.
REQ-013 BLANK  output  1  SHALL be 1 when the segment decoder must extinguish all segments.
REQ-014 FRAME  output  1  SHALL pulse high for one cycle when the index wraps from 3 to 0.

Function
REQ-015 A prescaler counter SHALL count 0..REFRESH_DIV-1 while EN=1 and generate an internal tick in the cycle it equals REFRESH_DIV-1, then return to 0.
REQ-016 The 2-bit index register {S0,S1} SHALL increment by 1 modulo 4 on each tick, so index 00 -> 01 -> 10 -> 11 -> 00; each digit SHALL be held exactly REFRESH_DIV cycles.
REQ-017 FRAME SHALL be registered and assert in the cycle after the tick that moves the index from 11 to 00.
REQ-018 LOAD=1 SHALL capture VALUE and DP_IN into a pending register and set a pending flag; a later LOAD before transfer SHALL overwrite the pending contents (last write wins).
REQ-019 The pending contents SHALL transfer to the display shadow register on the tick that wraps the index 11 -> 00, or on any cycle with EN=0, and the pending flag SHALL clear; the shadow SHALL never change mid-frame.
REQ-020 If LOAD and a transfer occur in the same cycle, the shadow SHALL take the previously pending data, and the new LOAD data SHALL remain pending.
REQ-021 DIGIT and DP SHALL be combinational selections from the shadow register by the current index: zero latency from index change.
REQ-022 With BLANK_LZ=1, digit k (k=0..2) SHALL be blanked when shadow nibbles 0..k are all zero and DP for digits 0..k is 0; digit 3 SHALL never be blanked by this rule.
REQ-023 BLANK SHALL be 1 when EN=0, or when REQ-022 blanks the current digit; otherwise 0.
REQ-024 EN=0 SHALL hold the prescaler at 0 and the index at its current value, and FRAME SHALL be 0; on EN 0->1 the first tick SHALL occur REFRESH_DIV cycles later.

Reset
REQ-025 rst_n=0 at a clock edge SHALL clear the prescaler, index (S0=0, S1=0), shadow, pending register and pending flag, and FRAME, regardless of EN, LOAD or mid-digit position.
REQ-026 During and after reset, until data is loaded, outputs SHALL be DIGIT=0, DP=0, FRAME=0, and BLANK = !EN or (BLANK_LZ and index<3).

Verification (REFRESH_DIV=4)
REQ-027 Reset, EN=1, LOAD VALUE=16'h1234, DP_IN=0 -> after the first frame wrap, index sequence 00,01,10,11 each 4 cycles; DIGIT 1,2,3,4; BLANK=0; FRAME high for one cycle per 16.
REQ-028 VALUE=16'h0050, BLANK_LZ=1 -> BLANK 1,1,0,0 for indices 00..11, DIGIT 0,0,5,0; with BLANK_LZ=0 -> BLANK all 0.
REQ-029 Mid-frame LOAD 16'hABCD while displaying 16'h1234 at index 01 -> DIGIT remains 2,3,4 for the rest of that frame; A,B,C,D is shown starting at the next index 00.
REQ-030 EN dropped at index 10 for 10 cycles -> S0,S1 hold 10, BLANK=1, FRAME=0; a LOAD made during that period appears immediately; after EN rises, index 11 is reached 4 cycles later.
REQ-031 rst_n pulsed low for one cycle at prescaler=2, index 11 with pending data -> next cycle: index 00, prescaler 0, DIGIT 0, pending discarded.
REQ-032 LOAD 16'h1111 then LOAD 16'h2222 in the same frame, with a LOAD 16'h3333 coinciding with the wrap tick -> the next frame shows 2222 and the following frame shows 3333.
